// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP+ACCESS per accepted single-word transfer.
// Optional: define AHB2APB_PSLVERR_EN to add PSLVERR and map APB slave errors to an AHB ERROR response.
module ahb2apb_bridge #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int HADDR_WIDTH = 32
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   HSEL,
    input  logic [HADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_WIDTH-1:0]  HWDATA,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [DATA_WIDTH-1:0]  HRDATA,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic [ADDR_WIDTH-1:0]  PADDR,
    output logic                   PWRITE,
    output logic [DATA_WIDTH-1:0]  PWDATA,
    input  logic [DATA_WIDTH-1:0]  PRDATA,
    input  logic                   PREADY
`ifdef AHB2APB_PSLVERR_EN
    ,
    input  logic                   PSLVERR
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                  state_q, state_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

    logic accept;
    logic bad_xfer;
    logic apb_slverr;

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign bad_xfer = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00);

`ifdef AHB2APB_PSLVERR_EN
    assign apb_slverr = PSLVERR;
`else
    assign apb_slverr = 1'b0;
`endif

    // Upper byte-address bits and the SEQ/NONSEQ distinction carry no meaning for this slave.
    generate
        if (HADDR_WIDTH > ADDR_WIDTH + 2) begin : g_unused_hi
            logic unused_bits;
            assign unused_bits = ^{HADDR[HADDR_WIDTH-1:ADDR_WIDTH+2], HTRANS[0]};
        end else begin : g_unused_lo
            logic unused_bits;
            assign unused_bits = HTRANS[0];
        end
    endgenerate

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        hrdata_d = hrdata_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_xfer) begin
                        state_d = ST_ERR1;
                    end else begin
                        paddr_d  = HADDR[ADDR_WIDTH+1:2];
                        pwrite_d = HWRITE;
                        state_d  = HWRITE ? ST_WDATA : ST_SETUP;
                    end
                end
            end
            ST_WDATA: begin
                pwdata_d = HWDATA;
                state_d  = ST_SETUP;
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    if (apb_slverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        if (!pwrite_q) begin
                            hrdata_d = PRDATA;
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            // A transfer offered during ERR2 is deliberately dropped; the master re-issues it.
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they leave a flop cleanly.
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
- Synchronous AHB-Lite slave to APB master bridge; sits directly upstream of the APB word memory and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA.
- Converts each accepted AHB single-word transfer into one APB SETUP+ACCESS transfer, stalls AHB with HREADYOUT until PREADY, and returns read data.
- AHB and APB sides share one clock; no CDC.

Parameters:
- ADDR_WIDTH, 16, APB word-address width; PADDR = HADDR[ADDR_WIDTH+1:2].
- DATA_WIDTH, 32, data width on both buses; only 32 is supported.
- HADDR_WIDTH, 32, AHB byte-address width; must be >= ADDR_WIDTH+2.

Ports:
- PCLK  in  1  single clock for both AHB and APB sides.
- PRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  AHB slave select.
- HADDR  in  HADDR_WIDTH  AHB byte address.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  AHB write control.
- HSIZE  in  3  AHB transfer size.
- HWDATA  in  DATA_WIDTH  AHB write data (valid in the data phase).
- HREADY  in  1  AHB bus ready (from mux).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB word address.
- PWRITE  out  1  APB write.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data; undriven (z) outside the read ACCESS phase.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (async, PRESETn=0): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0. Takes effect immediately, including mid-transfer. An APB transfer in flight is abandoned with no write commit guarantee.
- Accept: in IDLE, sample when HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ). Register HADDR and HWRITE.
- Non-accepted cycles: HTRANS IDLE or BUSY, or HSEL=0, leave the bridge in IDLE with OKAY and HREADYOUT=1.
- Error check at accept: HSIZE!=3'b010 or HADDR[1:0]!=0 → ERR1, then ERR2. No APB activity.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - ERR2 → IDLE. A new transfer offered during ERR2 is ignored; the master must cancel or re-issue it.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
  - IDLE → WDATA on write accept; → SETUP on read accept; → ERR1 on error.
  - WDATA: HREADYOUT=0; PWDATA<=HWDATA; → SETUP.
  - SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable; HREADYOUT=0; → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; HREADYOUT=0.
    - Stay while PREADY=0; no timeout.
    - On PREADY=1: for reads, HRDATA<=PRDATA; → IDLE.
  - Next cycle after ACCESS: PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA valid.
- PRDATA is sampled only in ACCESS with PREADY=1 and read. HRDATA holds its last read value otherwise and never samples z.
- Latency, zero-wait APB:
  - Read: address phase + 2 stall cycles, data on cycle 3.
  - Write: address phase + 3 stall cycles.
- Back-to-back: the completion cycle (IDLE, HREADYOUT=1) is also the next address phase and may accept immediately. PSEL deasserts for at least that one cycle between APB transfers.
- APB outputs: PSEL/PENABLE/PADDR/PWRITE/PWDATA are registered, glitch-free. PADDR/PWRITE/PWDATA hold their values after the transfer.

Optional Feature:
- Macro: AHB2APB_PSLVERR_EN.
- Defined:
  - Adds input PSLVERR (1 bit).
  - PSLVERR=1 sampled in ACCESS with PREADY=1 → ERR1/ERR2 two-cycle ERROR response instead of the OKAY completion. HRDATA is not updated.
- Undefined: no port; every APB completion is OKAY.

Test Plan:
- Write HADDR=0x0000_0010, HWDATA=0xDEAD_BEEF, HSIZE=2, PREADY tied 1 → PADDR=0x0004, PWDATA=0xDEAD_BEEF, PWRITE=1; SETUP then ACCESS one cycle each; HREADYOUT low 3 cycles; HRESP=0.
- Read back 0x10 → PSEL/PENABLE pattern 10,11; HRDATA=0xDEAD_BEEF with HREADYOUT=1 on cycle 3; HRESP=0.
- Read with PREADY low 4 cycles in ACCESS → PENABLE held 5 cycles, HREADYOUT low 6 cycles, PADDR stable throughout.
- HADDR=0x0000_0012 or HSIZE=1 → no PSEL; HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; back to OKAY.
- Back-to-back write 0x20=0x1234_5678 then read 0x20 issued on the completion cycle → PSEL low exactly one cycle between; HRDATA=0x1234_5678.
- PRESETn pulsed low during ACCESS → PSEL=PENABLE=0 and HREADYOUT=1 immediately; after release, next transfer completes normally. With AHB2APB_PSLVERR_EN defined: PSLVERR=1 at completion → HRESP=1 two-cycle response.
